input_debouncer: RTL and testbench

//  Conditions the raw PLC field inputs (IN bus) before they reach the input register.

---
 rtl/input_debouncer.sv | 100 ++++++++++
 tb/tb_input_debouncer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Field-input conditioner: two-flop synchronizer followed by a per-bit
// consecutive-sample debounce filter with registered rise/fall strobes.
module input_debouncer #(
   parameter int INPUT_NUM  = 8,
   parameter int DEB_CYCLES = 4,
   parameter int PRESCALE   = 1,
   parameter int CNT_W      = 3,
   parameter int PRE_W      = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [INPUT_NUM-1:0] in_raw,
   output logic [INPUT_NUM-1:0] in_clean,
   output logic [INPUT_NUM-1:0] rise,
   output logic [INPUT_NUM-1:0] fall,
   output logic                 change
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [INPUT_NUM-1:0] sync1;
   logic [INPUT_NUM-1:0] sync2;
   logic [PRE_W-1:0]     pre;
   logic                 tick;

   logic [CNT_W-1:0]     cnt      [INPUT_NUM];
   logic [CNT_W-1:0]     cnt_nxt  [INPUT_NUM];
   logic [INPUT_NUM-1:0] clean_nxt;
   logic [INPUT_NUM-1:0] rise_nxt;
   logic [INPUT_NUM-1:0] fall_nxt;

   assign tick = en & (pre == PRE_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre <= '0;
      end else if (en) begin
         if (pre == PRE_LAST) begin
            pre <= '0;
         end else begin
            pre <= pre + PRE_W'(1);
         end
      end
   end

   // Any sample agreeing with the accepted level restarts the run.
   always_comb begin
      clean_nxt = in_clean;
      rise_nxt  = '0;
      fall_nxt  = '0;
      for (int i = 0; i < INPUT_NUM; i++) begin
         cnt_nxt[i] = cnt[i];
         if (tick) begin
            if (sync2[i] == in_clean[i]) begin
               cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
               cnt_nxt[i]   = '0;
               clean_nxt[i] = sync2[i];
               rise_nxt[i]  = sync2[i];
               fall_nxt[i]  = ~sync2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < INPUT_NUM; i++) begin
            cnt[i] <= '0;
         end
         in_clean <= '0;
         rise     <= '0;
         fall     <= '0;
         change   <= 1'b0;
      end else begin
         for (int i = 0; i < INPUT_NUM; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
         in_clean <= clean_nxt;
         rise     <= rise_nxt;
         fall     <= fall_nxt;
         change   <= |(rise_nxt | fall_nxt);
      end
   end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: latency, pulse width, prescale,
// enable freeze, mid-count reset and simultaneous edges.
module tb_input_debouncer;

   logic       clk;
   logic       reset;
   logic       en;
   logic [7:0] in_raw;
   logic [7:0] in_clean;
   logic [7:0] rise;
   logic [7:0] fall;
   logic       change;

   logic       rst4;
   logic       en4;
   logic [7:0] in4;
   logic [7:0] in_clean4;
   logic [7:0] rise4;
   logic [7:0] fall4;
   logic       change4;

   int tests;
   int failed;

   input_debouncer #(
      .INPUT_NUM(8), .DEB_CYCLES(4), .PRESCALE(1), .CNT_W(3), .PRE_W(1)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .in_raw(in_raw),
      .in_clean(in_clean), .rise(rise), .fall(fall), .change(change)
   );

   input_debouncer #(
      .INPUT_NUM(8), .DEB_CYCLES(4), .PRESCALE(4), .CNT_W(3), .PRE_W(2)
   ) dut4 (
      .clk(clk), .reset(rst4), .en(en4), .in_raw(in4),
      .in_clean(in_clean4), .rise(rise4), .fall(fall4), .change(change4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      reset  = 1'b1;
      en     = 1'b1;
      in_raw = 8'hFF;
      rst4   = 1'b1;
      en4    = 1'b1;
      in4    = 8'h00;
      step(3);
      chk("reset_clean", in_clean, 8'h00);
      chk("reset_rise", rise, 8'h00);
      chk("reset_fall", fall, 8'h00);
      chk("reset_change", change, 1'b0);

      // 1: release with FF held, accepted at edge 6
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step(1);
         chk("t1_hold", in_clean, 8'h00);
         chk("t1_norise", rise, 8'h00);
      end
      step(1);
      chk("t1_clean", in_clean, 8'hFF);
      chk("t1_rise", rise, 8'hFF);
      chk("t1_fall", fall, 8'h00);
      chk("t1_change", change, 1'b1);
      step(1);
      chk("t1_rise_off", rise, 8'h00);
      chk("t1_change_off", change, 1'b0);
      chk("t1_clean_keep", in_clean, 8'hFF);

      in_raw = 8'h00;
      step(6);
      chk("back0_fall", fall, 8'hFF);
      chk("back0_clean", in_clean, 8'h00);
      step(1);
      chk("back0_fall_off", fall, 8'h00);

      // 2: 3-clock pulse rejected
      in_raw = 8'h01;
      step(3);
      in_raw = 8'h00;
      for (int k = 0; k < 8; k++) begin
         step(1);
         chk("t2_clean", in_clean, 8'h00);
         chk("t2_rise", rise, 8'h00);
      end
      chk("t2_cnt0", dut.cnt[0], 3'd0);

      // 3: 4-clock pulse accepted, then released
      in_raw = 8'h01;
      step(4);
      in_raw = 8'h00;
      step(1);
      chk("t3_early", in_clean, 8'h00);
      step(1);
      chk("t3_clean", in_clean, 8'h01);
      chk("t3_rise", rise, 8'h01);
      step(3);
      chk("t3_hold", in_clean, 8'h01);
      chk("t3_nofall", fall, 8'h00);
      step(1);
      chk("t3_fall", fall, 8'h01);
      chk("t3_clean0", in_clean, 8'h00);
      chk("t3_change", change, 1'b1);

      // 4: PRESCALE=4, ticks on edges 4,8,12,16 after release
      rst4 = 1'b0;
      in4  = 8'h08;
      step(15);
      chk("t4_early", in_clean4, 8'h00);
      chk("t4_norise", rise4, 8'h00);
      step(1);
      chk("t4_clean", in_clean4, 8'h08);
      chk("t4_rise", rise4, 8'h08);
      chk("t4_fall", fall4, 8'h00);
      chk("t4_change", change4, 1'b1);

      // 5: enable freeze at cnt=2
      in_raw = 8'h02;
      step(4);
      chk("t5_cnt2", dut.cnt[1], 3'd2);
      en = 1'b0;
      step(10);
      chk("t5_frozen_cnt", dut.cnt[1], 3'd2);
      chk("t5_frozen_clean", in_clean, 8'h00);
      en = 1'b1;
      step(1);
      chk("t5_cnt3", dut.cnt[1], 3'd3);
      chk("t5_not_yet", in_clean, 8'h00);
      step(1);
      chk("t5_clean", in_clean, 8'h02);
      chk("t5_rise", rise, 8'h02);

      // 5b: reset at cnt=2, full requalification
      in_raw = 8'h06;
      step(4);
      chk("t5b_cnt2", dut.cnt[2], 3'd2);
      reset = 1'b1;
      step(1);
      chk("t5b_rst_clean", in_clean, 8'h00);
      chk("t5b_rst_cnt", dut.cnt[2], 3'd0);
      reset = 1'b0;
      step(5);
      chk("t5b_hold", in_clean, 8'h00);
      step(1);
      chk("t5b_clean", in_clean, 8'h06);
      chk("t5b_rise", rise, 8'h06);

      // 6: simultaneous rise and fall on different bits
      in_raw = 8'h04;
      step(6);
      chk("t6_pre_fall", fall, 8'h02);
      chk("t6_pre_clean", in_clean, 8'h04);
      in_raw = 8'h02;
      step(5);
      chk("t6_hold", in_clean, 8'h04);
      step(1);
      chk("t6_rise", rise, 8'h02);
      chk("t6_fall", fall, 8'h04);
      chk("t6_change", change, 1'b1);
      chk("t6_clean", in_clean, 8'h02);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
